// File: rtl/pc_seq_pkg.sv
// rtl/pc_seq_pkg.sv - shared types and helpers for the program-counter sequencer
package pc_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } pc_state_t;

  // Sign-extend an 8-bit word offset; callers size-cast the result down to the PC width.
  function automatic logic [31:0] sext8(input logic [7:0] off);
    return {{24{off[7]}}, off};
  endfunction

endpackage

// File: rtl/pc_next_calc.sv
// rtl/pc_next_calc.sv - combinational next-PC selection for one RUN cycle
module pc_next_calc
  import pc_seq_pkg::*;
#(
  parameter int D = 12
) (
  input  logic [D-1:0] Prog_ctr,
  input  logic         Stall,
  input  logic         Halt,
  input  logic         Branch_en,
  input  logic         Cond,
  input  logic [7:0]   Branch_offset,
  output logic [D-1:0] next_pc,
  output logic         br_taken
);

  logic [D-1:0] off_ext;

  assign off_ext = D'(sext8(Branch_offset));

  // Priority: stall, then halt hold the PC; a taken branch adds the offset; otherwise step by one.
  always_comb begin
    br_taken = 1'b0;
    next_pc  = Prog_ctr;
    if (!Stall && !Halt) begin
      if (Branch_en && Cond) begin
        br_taken = 1'b1;
        next_pc  = Prog_ctr + off_ext;
      end else begin
        next_pc  = Prog_ctr + D'(1);
      end
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - PC register, run/halt FSM, watchdog and performance counters
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter int           D          = 12,
  parameter logic [D-1:0] RESET_PC   = '0,
  parameter int           CW         = 16,
  parameter int           MAX_CYCLES = 4095
) (
  input  logic          Clk,
  input  logic          Reset_n,
  input  logic          Start,
  input  logic          Stall,
  input  logic          Halt,
  input  logic          Branch_en,
  input  logic          Cond,
  input  logic [7:0]    Branch_offset,
  output logic [D-1:0]  Prog_ctr,
  output logic          Fetch_valid,
  output logic          Done,
  output logic          Timeout,
  output logic [CW-1:0] Cycle_cnt,
  output logic [CW-1:0] Branch_cnt
);

  localparam logic [CW-1:0] WD_LAST = CW'(MAX_CYCLES - 1);
  localparam logic [CW-1:0] CNT_MAX = '1;

  pc_state_t    state, next_state;
  logic         rst_meta, rst_int_n;
  logic [D-1:0] next_pc;
  logic         br_taken;
  logic         in_run, start_acc, halt_act, wd_fire;

  assign in_run    = (state == RUN);
  assign start_acc = Start && !in_run;
  assign halt_act  = in_run && !Stall && Halt;
  // The watchdog yields to a halt in the same cycle so a clean finish never reports a timeout.
  assign wd_fire   = in_run && (Cycle_cnt == WD_LAST) && !halt_act;

  pc_next_calc #(.D(D)) u_next (
    .Prog_ctr      (Prog_ctr),
    .Stall         (Stall),
    .Halt          (Halt),
    .Branch_en     (Branch_en),
    .Cond          (Cond),
    .Branch_offset (Branch_offset),
    .next_pc       (next_pc),
    .br_taken      (br_taken)
  );

  // Reset asserts immediately but releases only after two clean clock edges.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      rst_meta  <= 1'b0;
      rst_int_n <= 1'b0;
    end else begin
      rst_meta  <= 1'b1;
      rst_int_n <= rst_meta;
    end
  end

  // State register.
  always_ff @(posedge Clk or negedge rst_int_n) begin
    if (!rst_int_n) state <= IDLE;
    else            state <= next_state;
  end

  // Next-state selection: Start leaves IDLE/DONE, halt or watchdog leaves RUN.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (Start) next_state = RUN;
      RUN:     if (halt_act || wd_fire) next_state = DONE;
      DONE:    if (Start) next_state = RUN;
      default: next_state = IDLE;
    endcase
  end

  // State-decoded outputs.
  always_comb begin
    Fetch_valid = (state == RUN);
    Done        = (state == DONE);
  end

  // PC, counters and timeout flag; a watchdog cycle counts but does not retire.
  always_ff @(posedge Clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      Prog_ctr   <= RESET_PC;
      Cycle_cnt  <= '0;
      Branch_cnt <= '0;
      Timeout    <= 1'b0;
    end else if (start_acc) begin
      Prog_ctr   <= RESET_PC;
      Cycle_cnt  <= '0;
      Branch_cnt <= '0;
      Timeout    <= 1'b0;
    end else if (in_run) begin
      if (Cycle_cnt != CNT_MAX) Cycle_cnt <= Cycle_cnt + CW'(1);
      if (wd_fire) begin
        Timeout <= 1'b1;
      end else begin
        Prog_ctr <= next_pc;
        if (br_taken && (Branch_cnt != CNT_MAX)) Branch_cnt <= Branch_cnt + CW'(1);
      end
    end
  end

endmodule
